// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) registered mux stages with a global-stall valid/ready pipe.
// Define SHIFTER_ROTATE_EN to make mode 11 a rotate-left; otherwise mode 11 yields zero.
module shifter_pipe #(
  parameter  int WIDTH = 32,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  // Stage k moves data by 2^k when enabled. SRA fills from the current MSB, which
  // equals the original sign because every earlier SRA stage preserved it.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             en,
    input int unsigned      k
  );
    logic [WIDTH-1:0] r;
    int unsigned      step;
    step = 1 << k;
    r    = d;
    case (mode)
      MODE_SLL: if (en) r = d << step;
      MODE_SRL: if (en) r = d >> step;
      MODE_SRA: if (en) r = WIDTH'($signed(d) >>> step);
      MODE_ROL: begin
`ifdef SHIFTER_ROTATE_EN
        if (en) r = (d << step) | (d >> (WIDTH - step));
`else
        r = '0;
`endif
      end
    endcase
    return r;
  endfunction

  // Stage registers. The last stage needs no shamt/mode, so those stop one short.
  logic [SW-1:0][WIDTH-1:0] data_q;
  logic [SW-1:0][WIDTH-1:0] data_d;
  logic [SW-2:0][SW-1:0]    shamt_q;
  logic [SW-2:0][1:0]       mode_q;
  logic [SW-1:0]            valid_q;

  // Inputs seen by each stage: stage 0 reads the ports, stage k reads stage k-1.
  logic [SW-1:0][WIDTH-1:0] stg_data;
  logic [SW-1:0][SW-1:0]    stg_shamt;
  logic [SW-1:0][1:0]       stg_mode;
  logic [SW-1:0]            stg_valid;

  logic advance;

  assign stg_data  = {data_q[SW-2:0], in_data};
  assign stg_shamt = {shamt_q, in_shamt};
  assign stg_mode  = {mode_q, in_mode};
  assign stg_valid = {valid_q[SW-2:0], in_valid};

  // Stall the whole pipe only when a finished result is waiting on the consumer.
  assign advance   = ~valid_q[SW-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[SW-1];
  assign out_data  = data_q[SW-1];

  // NOTE: every variable an always_comb writes gets a value on all paths (here a
  // default first), otherwise synthesis infers a latch.
  always_comb begin
    data_d = '0;
    for (int k = 0; k < SW; k++) begin
      data_d[k] = shift_step(stg_data[k], stg_mode[k],
                             |(stg_shamt[k] & SW'(1 << k)), k);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor; blocking here would collapse the pipeline.
  // NOTE: data/shamt/mode are reset too, since out_data must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      valid_q <= '0;
    end else if (advance) begin
      data_q  <= data_d;
      shamt_q <= stg_shamt[SW-2:0];
      mode_q  <= stg_mode[SW-2:0];
      valid_q <= stg_valid;
    end
  end

endmodule
